// File: rtl/average_pkg.sv
// Shared definitions for the averaging blocks: FSM state encoding and
// width/rounding helpers derived from the sample width and window depth.
package average_pkg;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    function automatic int unsigned sum_width(input int unsigned bitwidth_sample,
                                              input int unsigned log2_depth);
        return bitwidth_sample + log2_depth;
    endfunction

    // DEPTH/2, added before the shift to round half up
    function automatic int unsigned round_offset(input int unsigned log2_depth);
        return (32'd1 << log2_depth) >> 1;
    endfunction

endpackage

// File: rtl/average_window_buffer.sv
// Window sample storage: one synchronous write port and an asynchronous read
// port at the same address, so the old slot value is visible before the write.
module average_window_buffer #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);

    if (DEPTH == 1) begin : g_single
        logic [WIDTH-1:0] slot_q;
        logic             unused_addr;

        assign unused_addr = ^addr;

        always_ff @(posedge clock) begin
            if (write_enable) begin
                slot_q <= write_data;
            end
        end

        assign read_data = slot_q;
    end else begin : g_array
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clock) begin
            if (write_enable) begin
                mem[addr] <= write_data;
            end
        end

        assign read_data = mem[addr];
    end

endmodule

// File: rtl/average_moving_window.sv
// Boxcar averager: keeps the last 2^LOG2_DEPTH accepted samples with a running
// sum and emits the rounded mean one cycle after every accepted sample.
module average_moving_window
    import average_pkg::*;
#(
    parameter int unsigned BITWIDTH_SAMPLE = 12,
    parameter int unsigned LOG2_DEPTH      = 3,
    parameter int unsigned INITIAL_VALUE   = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic [BITWIDTH_SAMPLE-1:0] sample_value,
    output logic [BITWIDTH_SAMPLE-1:0] averaged_value,
    output logic                       average_valid,
    output logic                       primed
);

    localparam int unsigned Depth = 32'd1 << LOG2_DEPTH;
    localparam int unsigned SumW  = sum_width(BITWIDTH_SAMPLE, LOG2_DEPTH);
    localparam int unsigned PtrW  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int unsigned CntW  = LOG2_DEPTH + 1;

    localparam logic [SumW-1:0]            SumInit    = SumW'(INITIAL_VALUE) << LOG2_DEPTH;
    localparam logic [SumW-1:0]            RoundOff   = SumW'(round_offset(LOG2_DEPTH));
    localparam logic [PtrW-1:0]            LastIdx    = PtrW'(Depth - 1);
    localparam logic [CntW-1:0]            FullCount  = CntW'(Depth);
    localparam logic [CntW-1:0]            LastCount  = CntW'(Depth - 1);
    localparam logic [BITWIDTH_SAMPLE-1:0] InitSample = BITWIDTH_SAMPLE'(INITIAL_VALUE);

    state_e                     state_q;
    logic [PtrW-1:0]            clear_index_q;
    logic [PtrW-1:0]            wr_ptr_q;
    logic [CntW-1:0]            fill_count_q;
    logic [SumW-1:0]            sum_q;
    logic [BITWIDTH_SAMPLE-1:0] averaged_q;
    logic                       average_valid_q;
    logic                       primed_q;
    logic                       ready_q;

    logic                       accept;
    logic                       buf_we;
    logic [PtrW-1:0]            buf_addr;
    logic [BITWIDTH_SAMPLE-1:0] buf_wdata;
    logic [BITWIDTH_SAMPLE-1:0] old_sample;
    logic [SumW-1:0]            sum_new;
    logic [PtrW-1:0]            wr_ptr_next;

    // clear wins over accept: a sample presented alongside clear is dropped
    always_comb begin
        accept      = ready_q && sample_valid && !clear;
        buf_we      = (state_q == StClear) || accept;
        buf_addr    = (state_q == StClear) ? clear_index_q : wr_ptr_q;
        buf_wdata   = (state_q == StClear) ? InitSample : sample_value;
        sum_new     = sum_q + SumW'(sample_value) - SumW'(old_sample);
        wr_ptr_next = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
    end

    average_window_buffer #(
        .WIDTH      (BITWIDTH_SAMPLE),
        .DEPTH      (Depth),
        .ADDR_WIDTH (PtrW)
    ) u_buffer (
        .clock        (clock),
        .write_enable (buf_we),
        .addr         (buf_addr),
        .write_data   (buf_wdata),
        .read_data    (old_sample)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StClear;
            clear_index_q   <= '0;
            wr_ptr_q        <= '0;
            fill_count_q    <= '0;
            sum_q           <= SumInit;
            averaged_q      <= InitSample;
            average_valid_q <= 1'b0;
            primed_q        <= 1'b0;
            ready_q         <= 1'b0;
        end else if (clear) begin
            state_q         <= StClear;
            clear_index_q   <= '0;
            wr_ptr_q        <= '0;
            fill_count_q    <= '0;
            sum_q           <= SumInit;
            averaged_q      <= InitSample;
            average_valid_q <= 1'b0;
            primed_q        <= 1'b0;
            ready_q         <= 1'b0;
        end else begin
            average_valid_q <= 1'b0;
            unique case (state_q)
                StClear: begin
                    clear_index_q <= clear_index_q + 1'b1;
                    if (clear_index_q == LastIdx) begin
                        clear_index_q <= '0;
                        state_q       <= StRun;
                        ready_q       <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        wr_ptr_q        <= wr_ptr_next;
                        sum_q           <= sum_new;
                        averaged_q      <= BITWIDTH_SAMPLE'((sum_new + RoundOff) >> LOG2_DEPTH);
                        average_valid_q <= 1'b1;
                        if (fill_count_q != FullCount) begin
                            fill_count_q <= fill_count_q + 1'b1;
                        end
                        if (fill_count_q == LastCount) begin
                            primed_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StClear;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready   = ready_q;
    assign averaged_value = averaged_q;
    assign average_valid  = average_valid_q;
    assign primed         = primed_q;

endmodule
